// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Brief    : Collapsing-queue reservation station with CDB wakeup and
//            oldest-ready issue. Optional macro: RS_DISPATCH_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module reservation_station #(
    parameter int         DEPTH = 4,
    parameter logic [3:0] UNIT  = 4'b1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [3:0]   rs_dest,
    input  logic [113:0] dc2rs,
    output logic         rs_full,
    input  logic         cdb_valid,
    input  logic [5:0]   cdb_tag,
    input  logic [31:0]  cdb_data,
    output logic         issue_valid,
    input  logic         issue_ready,
    output logic [9:0]   issue_inst,
    output logic [5:0]   issue_rob,
    output logic [31:0]  issue_opr1,
    output logic [31:0]  issue_opr2,
    output logic [31:0]  issue_offset
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

    // Field order matches the dispatch bus so it can be assigned directly.
    typedef struct packed {
        logic [9:0]  inst;
        logic [5:0]  rob;
        logic [32:0] opr1;
        logic [32:0] opr2;
        logic [31:0] offset;
    } entry_t;

    function automatic logic [32:0] f_wake(
        input logic [32:0] opr,
        input logic        hit_en,
        input logic [5:0]  tag,
        input logic [31:0] data
    );
        if (hit_en && !opr[32] && (opr[5:0] == tag)) begin
            return {1'b1, data};
        end
        return opr;
    endfunction

    entry_t               r_ent   [DEPTH];
    entry_t               w_woken [DEPTH];
    entry_t               w_next  [DEPTH];
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_full;

    entry_t               w_disp_raw;
    entry_t               w_disp;
    entry_t               w_issue_ent;
    logic [DEPTH-1:0]     w_ready;
    logic [c_idx_w-1:0]   w_sel;
    logic                 w_do_issue;
    logic                 w_accept;
    logic [c_cnt_w-1:0]   w_count_after;
    logic [c_cnt_w-1:0]   w_count_next;

    assign rs_full = r_full;

    // Readiness looks only at stored state, so a just-dispatched entry waits a cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign w_ready[gi] = (c_cnt_w'(gi) < r_count)
                           && r_ent[gi].opr1[32] && r_ent[gi].opr2[32];
    end

    always_comb begin
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel = c_idx_w'(i);
            end
        end
    end

    assign issue_valid  = |w_ready;
    assign w_issue_ent  = r_ent[w_sel];
    assign w_do_issue   = issue_valid & issue_ready;

    assign issue_inst   = issue_valid ? w_issue_ent.inst         : '0;
    assign issue_rob    = issue_valid ? w_issue_ent.rob          : '0;
    assign issue_opr1   = issue_valid ? w_issue_ent.opr1[31:0]   : '0;
    assign issue_opr2   = issue_valid ? w_issue_ent.opr2[31:0]   : '0;
    assign issue_offset = issue_valid ? w_issue_ent.offset       : '0;

    assign w_disp_raw = dc2rs;
    assign w_accept   = (|(rs_dest & UNIT)) && !r_full;

    always_comb begin
        w_disp = w_disp_raw;
`ifdef RS_DISPATCH_BYPASS_EN
        w_disp.opr1 = f_wake(w_disp_raw.opr1, cdb_valid, cdb_tag, cdb_data);
        w_disp.opr2 = f_wake(w_disp_raw.opr2, cdb_valid, cdb_tag, cdb_data);
`endif
    end

    // Wakeup, then collapse over the issued slot, then append at the new tail.
    always_comb begin
        w_count_after = r_count - c_cnt_w'(w_do_issue);
        w_count_next  = w_count_after + c_cnt_w'(w_accept);
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i]      = r_ent[i];
            w_woken[i].opr1 = f_wake(r_ent[i].opr1, cdb_valid, cdb_tag, cdb_data);
            w_woken[i].opr2 = f_wake(r_ent[i].opr2, cdb_valid, cdb_tag, cdb_data);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = w_woken[i];
        end
        if (w_do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (c_idx_w'(i) >= w_sel) begin
                    w_next[i] = w_woken[i + 1];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_accept && (c_cnt_w'(i) == w_count_after)) begin
                w_next[i] = w_disp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_full_count);
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_next[i];
            end
        end
    end

endmodule
`default_nettype wire
